// File: rtl/piece_lock_merge.sv
// piece_lock_merge: owns the settled playfield, merges a landed tetromino,
// then drives the line-break stage one pass at a time until no full row
// (below row 0) remains. Reports lines cleared and a sticky game-over flag.
module piece_lock_merge #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lock_valid_i,
  output logic                       lock_ready_o,
  input  logic [3:0][3:0]            piece_x_i,
  input  logic [3:0][4:0]            piece_y_i,
  output logic [ROWS-1:0][COLS-1:0]  board_o,
  output logic                       clear_mode_o,
  input  logic [ROWS-1:0][COLS-1:0]  cleared_board_i,
  output logic                       done_o,
  output logic [2:0]                 lines_cleared_o,
  output logic                       game_over_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MERGE      = 3'd1,
    CHECK      = 3'd2,
    CLEAR_REQ  = 3'd3,
    CLEAR_WAIT = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t                      state_q;
  logic [ROWS-1:0][COLS-1:0]   board_q;
  logic [3:0][3:0]             px_q;
  logic [3:0][4:0]             py_q;
  logic                        clear_mode_q;
  logic                        done_q;
  logic [2:0]                  lines_q;
  logic                        game_over_q;
  logic                        lock_ready_q;

  logic [ROWS-1:0][COLS-1:0]   cell_mask_s;
  logic                        range_err_s;
  logic                        overlap_s;
  logic                        full_s;

  // Decode the latched piece into a board-shaped mask and flag off-board cells.
  always_comb begin
    cell_mask_s = '0;
    range_err_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      range_err_s = range_err_s | (px_q[i] >= 4'(COLS)) | (py_q[i] >= 5'(ROWS));
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        for (int i = 0; i < 4; i++) begin
          cell_mask_s[r][c] = cell_mask_s[r][c] |
                              ((px_q[i] == 4'(c)) && (py_q[i] == 5'(r)));
        end
      end
    end
  end

  // Collision and full-row detection; row 0 is never a clear candidate.
  always_comb begin
    overlap_s = |(board_q & cell_mask_s);
    full_s    = 1'b0;
    for (int r = 1; r < ROWS; r++) begin
      full_s = full_s | (&board_q[r]);
    end
  end

  // Lock sequencing FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      board_q      <= '0;
      px_q         <= '0;
      py_q         <= '0;
      clear_mode_q <= 1'b0;
      done_q       <= 1'b0;
      lines_q      <= 3'd0;
      game_over_q  <= 1'b0;
      lock_ready_q <= 1'b1;
    end else begin
      clear_mode_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lock_valid_i && lock_ready_q) begin
            px_q         <= piece_x_i;
            py_q         <= piece_y_i;
            lines_q      <= 3'd0;
            lock_ready_q <= 1'b0;
            state_q      <= MERGE;
          end else begin
            state_q <= IDLE;
          end
        end
        MERGE: begin
          if (range_err_s || overlap_s) begin
            game_over_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            board_q <= board_q | cell_mask_s;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (full_s) begin
            clear_mode_q <= 1'b1;
            state_q      <= CLEAR_REQ;
          end else begin
            // Anything left in the hidden top row means the stack topped out.
            if (board_q[0] != '0) begin
              game_over_q <= 1'b1;
            end else begin
              game_over_q <= game_over_q;
            end
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        CLEAR_REQ: begin
          if (lines_q != 3'd7) begin
            lines_q <= lines_q + 3'd1;
          end else begin
            lines_q <= lines_q;
          end
          state_q <= CLEAR_WAIT;
        end
        CLEAR_WAIT: begin
          board_q <= cleared_board_i;
          state_q <= CHECK;
        end
        DONE: begin
          lock_ready_q <= !game_over_q;
          state_q      <= IDLE;
        end
        default: begin
          lock_ready_q <= !game_over_q;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign lock_ready_o    = lock_ready_q;
  assign board_o         = board_q;
  assign clear_mode_o    = clear_mode_q;
  assign done_o          = done_q;
  assign lines_cleared_o = lines_q;
  assign game_over_o     = game_over_q;

endmodule

// File: tb/tb_piece_lock_merge.sv
// Directed bench for piece_lock_merge with a behavioural line-break stage.
module tb_piece_lock_merge;
  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic                      clk;
  logic                      reset;
  logic                      lock_valid;
  logic                      lock_ready;
  logic [3:0][3:0]           piece_x;
  logic [3:0][4:0]           piece_y;
  logic [ROWS-1:0][COLS-1:0] board;
  logic                      clear_mode;
  logic [ROWS-1:0][COLS-1:0] cleared_board;
  logic                      done;
  logic [2:0]                lines_cleared;
  logic                      game_over;

  int checks;
  int errors;

  piece_lock_merge #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk             (clk),
    .reset           (reset),
    .lock_valid_i    (lock_valid),
    .lock_ready_o    (lock_ready),
    .piece_x_i       (piece_x),
    .piece_y_i       (piece_y),
    .board_o         (board),
    .clear_mode_o    (clear_mode),
    .cleared_board_i (cleared_board),
    .done_o          (done),
    .lines_cleared_o (lines_cleared),
    .game_over_o     (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line-break stage: remove the lowest full row (rows 1..ROWS-1), shift above down.
  function automatic logic [ROWS-1:0][COLS-1:0] line_break(input logic [ROWS-1:0][COLS-1:0] b);
    logic [ROWS-1:0][COLS-1:0] o;
    int found;
    o = b;
    found = -1;
    for (int r = ROWS - 1; r >= 1; r--) begin
      if (found < 0 && b[r] == {COLS{1'b1}}) found = r;
    end
    if (found > 0) begin
      for (int i = found; i >= 1; i--) o[i] = b[i-1];
      o[0] = '0;
    end
    return o;
  endfunction

  always @(posedge clk) cleared_board <= line_break(board);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one lock, then trace cycles T+1.. up to one cycle past done.
  task automatic do_lock(input logic [3:0][3:0] xs, input logic [3:0][4:0] ys,
                         output int done_k, output logic [31:0] clr_bits,
                         output logic go_at_done, output logic [2:0] lines_at_done,
                         output logic ready_after);
    @(negedge clk);
    piece_x    = xs;
    piece_y    = ys;
    lock_valid = 1'b1;
    @(posedge clk);
    #1;
    lock_valid    = 1'b0;
    done_k        = 0;
    clr_bits      = '0;
    go_at_done    = 1'b0;
    lines_at_done = 3'd0;
    ready_after   = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (clear_mode) clr_bits[k] = 1'b1;
      if (done_k != 0 && k == done_k + 1) begin
        ready_after = lock_ready;
        break;
      end
      if (done && done_k == 0) begin
        done_k        = k;
        go_at_done    = game_over;
        lines_at_done = lines_cleared;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int          dk;
  logic [31:0] cb;
  logic        go_d;
  logic [2:0]  ln;
  logic        rdy;
  int          seen_done;

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    lock_valid = 1'b0;
    piece_x    = '0;
    piece_y    = '0;
    do_reset();
    #1;
    check("rst_ready", {31'd0, lock_ready}, 32'd1);
    check("rst_board_zero", {31'd0, board == '0}, 32'd1);
    check("rst_clear", {31'd0, clear_mode}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_lines", {29'd0, lines_cleared}, 32'd0);
    check("rst_go", {31'd0, game_over}, 32'd0);

    // Simple lock on an empty board.
    do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {5'd19, 5'd19, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    check("t1_done_k", dk, 32'd3);
    check("t1_no_clear", cb, 32'd0);
    check("t1_lines", {29'd0, ln}, 32'd0);
    check("t1_go", {31'd0, go_d}, 32'd0);
    check("t1_ready_back", {31'd0, rdy}, 32'd1);
    check("t1_row19", {22'd0, board[19]}, 32'h00F);

    // Duplicate coordinates within a piece are legal.
    do_lock({4'd5, 4'd5, 4'd5, 4'd5}, {5'd10, 5'd10, 5'd10, 5'd10}, dk, cb, go_d, ln, rdy);
    check("dup_done_k", dk, 32'd3);
    check("dup_row10", {22'd0, board[10]}, 32'h020);
    check("dup_go", {31'd0, go_d}, 32'd0);

    // Single-line clear: build row19 = 3F0, row18 = 030, then fill 0..3.
    do_reset();
    do_lock({4'd7, 4'd6, 4'd5, 4'd4}, {5'd19, 5'd19, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    check("t2_pre1_done", dk, 32'd3);
    do_lock({4'd5, 4'd4, 4'd9, 4'd8}, {5'd18, 5'd18, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    check("t2_pre2_row19", {22'd0, board[19]}, 32'h3F0);
    do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {5'd19, 5'd19, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    check("t2_clear_at3", cb, 32'h0000_0008);
    check("t2_done_k", dk, 32'd6);
    check("t2_lines", {29'd0, ln}, 32'd1);
    check("t2_row19", {22'd0, board[19]}, 32'h030);
    check("t2_row18", {22'd0, board[18]}, 32'h000);

    // Four-line clear with a vertical I piece in column 0.
    do_reset();
    for (int c = 1; c < COLS; c++) begin
      do_lock({4'(c), 4'(c), 4'(c), 4'(c)}, {5'd19, 5'd18, 5'd17, 5'd16}, dk, cb, go_d, ln, rdy);
    end
    check("t3_pre_row16", {22'd0, board[16]}, 32'h3FE);
    check("t3_pre_row19", {22'd0, board[19]}, 32'h3FE);
    do_lock({4'd0, 4'd0, 4'd0, 4'd0}, {5'd19, 5'd18, 5'd17, 5'd16}, dk, cb, go_d, ln, rdy);
    check("t3_clear_pulses", cb, 32'h0000_1248);
    check("t3_done_k", dk, 32'd15);
    check("t3_lines", {29'd0, ln}, 32'd4);
    check("t3_board_zero", {31'd0, board == '0}, 32'd1);
    check("t3_go", {31'd0, go_d}, 32'd0);

    // Overlap with an occupied cell.
    do_reset();
    do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {5'd19, 5'd19, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    do_lock({4'd6, 4'd5, 4'd4, 4'd3}, {5'd19, 5'd19, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    check("t4_ovl_done_k", dk, 32'd2);
    check("t4_ovl_go", {31'd0, go_d}, 32'd1);
    check("t4_ovl_row19", {22'd0, board[19]}, 32'h00F);
    check("t4_ovl_ready", {31'd0, rdy}, 32'd0);
    // Further lock requests are ignored while game_over is set.
    @(negedge clk);
    piece_x    = {4'd9, 4'd8, 4'd7, 4'd6};
    piece_y    = {5'd10, 5'd10, 5'd10, 5'd10};
    lock_valid = 1'b1;
    seen_done  = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1;
    end
    lock_valid = 1'b0;
    check("t4_ignored_done", seen_done, 32'd0);
    check("t4_ignored_ready", {31'd0, lock_ready}, 32'd0);
    check("t4_frozen_row10", {22'd0, board[10]}, 32'h000);

    // Column out of range.
    do_reset();
    do_lock({4'd1, 4'd0, 4'd10, 4'd2}, {5'd19, 5'd19, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    check("t4_x10_done_k", dk, 32'd2);
    check("t4_x10_go", {31'd0, go_d}, 32'd1);
    check("t4_x10_board", {31'd0, board == '0}, 32'd1);

    // Top-out: bits left in row 0, no full rows.
    do_reset();
    do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {5'd0, 5'd0, 5'd0, 5'd0}, dk, cb, go_d, ln, rdy);
    check("t5_done_k", dk, 32'd3);
    check("t5_go", {31'd0, go_d}, 32'd1);
    check("t5_ready", {31'd0, rdy}, 32'd0);

    // Reset during CLEAR_WAIT aborts the lock.
    do_reset();
    do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {5'd19, 5'd19, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    do_lock({4'd7, 4'd6, 4'd5, 4'd4}, {5'd19, 5'd19, 5'd19, 5'd19}, dk, cb, go_d, ln, rdy);
    @(negedge clk);
    piece_x    = {4'd9, 4'd8, 4'd9, 4'd8};
    piece_y    = {5'd18, 5'd18, 5'd19, 5'd19};
    lock_valid = 1'b1;
    @(posedge clk);
    #1;
    lock_valid = 1'b0;
    seen_done  = 0;
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) check("t6_clear_at3", {31'd0, clear_mode}, 32'd1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_board_zero", {31'd0, board == '0}, 32'd1);
    check("t6_clear", {31'd0, clear_mode}, 32'd0);
    check("t6_go", {31'd0, game_over}, 32'd0);
    check("t6_ready", {31'd0, lock_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (done) seen_done = 1;
      @(posedge clk);
      #1;
    end
    check("t6_no_done", seen_done, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piece_lock_merge.md
# piece_lock_merge

Owns the settled-block playfield register and sequences everything that happens when a falling tetromino lands. It accepts a lock request carrying the four cell coordinates of the landed piece and merges them into the board. It then drives the downstream line-break stage one pass at a time until no full row remains, and reports the number of lines cleared and any game-over condition. Its board output feeds the line-break stage's settled-block input, and the line-break stage's registered result is fed back here.

## Interface
- ROWS, 20, playfield rows; row 0 is the top, row ROWS-1 the bottom
- COLS, 10, playfield columns; a row is full when all COLS bits are 1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- lock_valid  in  1  landed piece presented
- lock_ready  out  1  block can accept a lock
- piece_x  in  4x4  column of each of the 4 cells
- piece_y  in  4x5  row of each of the 4 cells
- board  out  [COLS-1:0] x ROWS  settled playfield register, fed to the line-break stage
- clear_mode  out  1  one-cycle line-break request to the downstream stage
- cleared_board  in  [COLS-1:0] x ROWS  line-break stage result; valid one cycle after clear_mode
- done  out  1  one-cycle pulse when lock processing finishes
- lines_cleared  out  3  rows removed by the last lock; valid from done onward
- game_over  out  1  sticky fault/top-out flag

## Operation
- States: IDLE, MERGE, CHECK, CLEAR_REQ, CLEAR_WAIT, DONE.
- IDLE: lock_ready = !game_over. On lock_valid && lock_ready, latch piece_x/piece_y, clear lines_cleared, go to MERGE. lock_valid while not ready is ignored; no queueing.
- MERGE:
  - Validate first. If any cell has x ≥ COLS or y ≥ ROWS, or any cell hits an already-set board bit, set game_over, leave board unchanged, go to DONE.
  - Otherwise OR all four cells into board and go to CHECK. Duplicate coordinates within one piece are legal; OR semantics apply.
- CHECK:
  - full = any row r in 1..ROWS-1 with board[r] all ones. Row 0 is never tested because the downstream stage cannot clear it.
  - If full, go to CLEAR_REQ. Otherwise, if board[0] ≠ 0, set game_over (top-out). Then go to DONE.
- CLEAR_REQ: clear_mode = 1; board held stable; lines_cleared += 1; go to CLEAR_WAIT.
- CLEAR_WAIT: board ← cleared_board; go to CHECK. Exactly one row, the lowest full row, is removed per pass. A 4-line clear therefore takes 4 passes.
- DONE: done = 1 for this cycle; go to IDLE.
- lines_cleared saturates at 7. It cannot exceed 4 in legal play.
- game_over is sticky until reset. While set, lock_ready stays 0 and board is frozen.
- Reset values: state IDLE, board all zero, clear_mode 0, done 0, lines_cleared 0, game_over 0, lock_ready 1 in the first cycle after reset.
- Reset mid-operation, in any state, aborts the lock. It has priority over every update, including a concurrent board write in CLEAR_WAIT.

## Timing
- Accept in cycle T (IDLE, handshake true). MERGE is T+1, with board updated at the end of T+1. CHECK is T+2.
- Each clear pass costs 3 cycles: CLEAR_REQ, CLEAR_WAIT, CHECK.
- With n lines cleared: done is high in cycle T+3+3n, and lock_ready returns high in T+4+3n.
- Invalid or overlapping lock: done in T+2, game_over visible from T+2.
- clear_mode is high for exactly one cycle per pass, never in two consecutive cycles. board is constant during that cycle and the following one.
- The line-break stage registers its output every cycle. Only the value sampled in CLEAR_WAIT is used.
- board changes only at the end of MERGE or CLEAR_WAIT.

## Test plan
- Empty board, lock cells (0,19)(1,19)(2,19)(3,19) → board[19] = 10'h00F after T+1; no clear_mode; done at T+3; lines_cleared = 0; game_over = 0.
- board[19] = 10'h3F0 preloaded via prior locks, lock (0..3,19) → one clear_mode pulse at T+3; done at T+6; lines_cleared = 1; board[19] equals the old board[18].
- Rows 16–19 each = 10'h3FE, vertical I piece at x = 0, y = 16..19 → 4 clear_mode pulses spaced 3 cycles apart; done at T+15; lines_cleared = 4; rows 16–19 zero.
- Lock overlapping an occupied cell, or with x = 10 → board unchanged; game_over = 1; done at T+2; lock_ready stays 0 for subsequent lock_valid.
- Lock leaving bits in row 0 with no full rows → done at T+3 with game_over = 1.
- Assert reset in CLEAR_WAIT → next cycle: board zero, clear_mode 0, game_over 0, lock_ready 1; no done pulse.
